// File: rtl/mem_bus_arbiter.sv
// Shares the single memory port between instruction fetch and data access.
// Round-robin grant on conflict, registered req/ready handshake, bus timeout.
module mem_bus_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_sel,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        bus_err,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_sel,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic        last_d;
  logic [7:0]  cnt;
  logic        grant_d;
  logic        finish;

  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = d_req & ~d_ack;

  // D wins when alone, or on conflict when IF had the previous grant
  assign grant_d = d_req & (~if_req | ~last_d);
  // mem_ready on the final counted cycle still counts as success
  assign finish  = mem_ready | (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_d    <= 1'b0;
      cnt       <= 8'd0;
      mem_ce    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_sel   <= 4'd0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= 32'd0;
      d_rdata   <= 32'd0;
      bus_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (d_req | if_req) begin
            mem_ce <= 1'b1;
            if (grant_d) begin
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_sel   <= d_sel;
              last_d    <= 1'b1;
              state     <= BUSY_D;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= 32'd0;
              mem_sel   <= 4'hF;
              last_d    <= 1'b0;
              state     <= BUSY_IF;
            end
          end
        end
        BUSY_IF, BUSY_D: begin
          cnt <= cnt + 8'd1;
          if (finish) begin
            mem_ce  <= 1'b0;
            mem_we  <= 1'b0;
            bus_err <= ~mem_ready;
            if (state == BUSY_D) begin
              d_ack   <= 1'b1;
              d_rdata <= mem_ready ? mem_rdata : 32'd0;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= mem_ready ? mem_rdata : 32'd0;
            end
            state <= DONE;
          end
        end
        DONE: begin
          if_ack  <= 1'b0;
          d_ack   <= 1'b0;
          bus_err <= 1'b0;
          cnt     <= 8'd0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter against a transaction-level model of
// grant order, transfer timing, timeout and returned data.
module tb_mem_bus_arbiter;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_sel;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        bus_err;
  logic        stall_if;
  logic        stall_mem;
  logic        mem_ce;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_sel;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int n_checks = 0;
  int n_fail   = 0;
  bit model_last_d;

  mem_bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_sel(d_sel),
    .d_ack(d_ack), .d_rdata(d_rdata), .bus_err(bus_err),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_sel(mem_sel), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One transfer starting from IDLE with the granted request already pending.
  // dly = BUSY cycles with mem_ready low before it goes high (>= TIMEOUT: never).
  task automatic xfer(input bit is_d, input int dly, input logic [31:0] rd, input bit keep);
    logic [71:0] exp_bus;
    bit          ok;
    bit          done;
    int          last;
    exp_bus = is_d ? {2'b0, 1'b1, d_we, d_sel, d_addr, d_wdata}
                   : {2'b0, 1'b1, 1'b0, 4'hF, if_addr, 32'h0};
    ok   = (dly <= TIMEOUT - 1);
    last = ok ? dly : TIMEOUT - 1;
    mem_ready = 1'($urandom_range(0, 1));
    tick;
    model_last_d = is_d;
    check("grant_bus", {2'b0, mem_ce, mem_we, mem_sel, mem_addr, mem_wdata}, exp_bus);
    check("grant_stall", {stall_if, stall_mem}, {if_req, d_req});
    done = 1'b0;
    for (int k = 0; k < TIMEOUT + 4 && !done; k++) begin
      mem_ready = (k == dly);
      mem_rdata = (k == dly) ? rd : $urandom;
      tick;
      if (if_ack | d_ack) begin
        done = 1'b1;
        check("ack_cycle", 72'(k), 72'(last));
        check("ack_who", {if_ack, d_ack}, {!is_d, is_d});
        check("bus_err", bus_err, !ok);
        check("rdata", is_d ? d_rdata : if_rdata, ok ? rd : 32'd0);
        check("stall_at_ack", is_d ? stall_mem : stall_if, 1'b0);
        check("ce_drop", {mem_ce, mem_we}, 2'b0);
      end else begin
        check("busy_hold", {2'b0, mem_ce, mem_we, mem_sel, mem_addr, mem_wdata}, exp_bus);
      end
    end
    if (!done) check("ack_seen", 1'b0, 1'b1);
    if (!keep) begin
      if (is_d) d_req = 1'b0;
      else      if_req = 1'b0;
    end
    mem_ready = 1'($urandom_range(0, 1));
    tick;
    check("done_clear", {if_ack, d_ack, bus_err, mem_ce}, 4'b0);
  endtask

  task automatic set_d(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s);
    d_we = we; d_addr = a; d_wdata = wd; d_sel = s;
  endtask

  function automatic int pick_dly();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)  return $urandom_range(0, 4);
    if (r == 7) return TIMEOUT - 2;
    if (r == 8) return TIMEOUT - 1;
    return 99;
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bit first_d;
    int pat;
    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0;
    set_d(1'b0, '0, '0, '0);
    mem_rdata = '0; mem_ready = 1'b0;
    tick; tick;
    rst = 1'b0;
    model_last_d = 1'b0;
    check("rst_mem", {mem_ce, mem_we, mem_sel, mem_addr, mem_wdata}, '0);
    check("rst_ack", {if_ack, d_ack, bus_err}, '0);
    check("rst_rdata", {if_rdata, d_rdata}, '0);
    check("rst_stall", {stall_if, stall_mem}, '0);

    // Single fetch, memory ready in its first cycle
    if_req = 1'b1; if_addr = 32'h4;
    xfer(1'b0, 0, 32'h24010001, 1'b0);

    // Conflict: D first, IF follows without re-request, next conflict to D
    if_req = 1'b1; if_addr = 32'h8; d_req = 1'b1;
    set_d(1'b1, 32'h100, 32'hDEADBEEF, 4'h3);
    xfer(1'b1, 0, $urandom, 1'b0);
    xfer(1'b0, 1, 32'h11112222, 1'b0);
    if_req = 1'b1; d_req = 1'b1;
    xfer(1'b1, 5, 32'h33334444, 1'b0);
    xfer(1'b0, 0, 32'h55556666, 1'b0);

    // Timeout on a fetch
    if_req = 1'b1; if_addr = 32'h40;
    xfer(1'b0, 99, 32'h77778888, 1'b0);

    // Fetch kept high through DONE is regranted only after DONE
    if_req = 1'b1; if_addr = 32'h80;
    xfer(1'b0, 0, 32'h0A0A0A0A, 1'b1);
    if_addr = 32'h84;
    xfer(1'b0, 2, 32'h0B0B0B0B, 1'b0);

    // Reset in BUSY_D abandons the transfer and restores last_grant=IF
    d_req = 1'b1; set_d(1'b0, 32'h200, 32'h0, 4'hF);
    mem_ready = 1'b0;
    tick;
    check("rst_busy_ce", mem_ce, 1'b1);
    tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0; d_req = 1'b0;
    model_last_d = 1'b0;
    check("rst_mid_ce", mem_ce, 1'b0);
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      tick;
      check("rst_mid_noack", {d_ack, if_ack, mem_ce}, 3'b0);
    end
    mem_ready = 1'b0;
    if_req = 1'b1; if_addr = 32'hC; d_req = 1'b1;
    set_d(1'b0, 32'h300, 32'h0, 4'h1);
    xfer(1'b1, 1, 32'hCAFEF00D, 1'b0);
    xfer(1'b0, 0, 32'h12345678, 1'b0);

    // Randomized rounds against the model's round-robin order
    for (int r = 0; r < 60; r++) begin
      pat = $urandom_range(1, 3);
      if_addr = $urandom & 32'hFFFF_FFFC;
      set_d(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      if_req = pat[0];
      d_req  = pat[1];
      first_d = (pat == 3) ? !model_last_d : pat[1];
      xfer(first_d, pick_dly(), $urandom, 1'b0);
      if (pat == 3) xfer(!first_d, pick_dly(), $urandom, 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        mem_ready = 1'($urandom_range(0, 1));
        tick;
        check("idle_quiet", {mem_ce, if_ack, d_ack}, 3'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
